// File: rtl/fpu_bus_initiator_if.sv
// Request/response and TinyQV peripheral bus signals for the FPU bus initiator.
//
// Handshakes:
//   req: the request transfers on a rising clock edge where req_valid && req_ready.
//        The initiator raises req_ready only while idle.
//   rsp: the response transfers on a rising clock edge where rsp_valid && rsp_ready.
//        Once raised, rsp_valid, rsp_result and rsp_err stay stable until that edge.
//   bus: a strobe (write_n or read_n == 2'b10) is held with stable address and
//        wdata until a cycle in which bus_data_ready is 1. The access completes
//        at the end of that cycle.
interface fpu_bus_initiator_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic [1:0]        req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_err;
  logic [ADDR_W-1:0] bus_address;
  logic [31:0]       bus_wdata;
  logic [1:0]        bus_write_n;
  logic [1:0]        bus_read_n;
  logic [31:0]       bus_rdata;
  logic              bus_data_ready;

  // Initiator side.
  modport master (
    input  req_valid, req_a, req_b, req_op, rsp_ready, bus_rdata, bus_data_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           bus_address, bus_wdata, bus_write_n, bus_read_n
  );

  // Requester / peripheral side.
  modport slave (
    output req_valid, req_a, req_b, req_op, rsp_ready, bus_rdata, bus_data_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           bus_address, bus_wdata, bus_write_n, bus_read_n
  );
endinterface

// File: rtl/fpu_bus_initiator.sv
// Bus initiator for the FPU peripheral. It takes one (A, B, op) request and
// runs the register sequence: write A (0x00), write B (0x04), write control
// (0x08), poll busy (0x10) until clear, then read the result (0x0C).
// Bus outputs are decoded from the state register alone. A strobe therefore
// starts the cycle after the state is entered, and reset drops it immediately.
module fpu_bus_initiator #(
  parameter int POLL_MAX = 64,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  fpu_bus_initiator_if.master bus,
  output logic [2:0]          state_o
);

  localparam int CNT_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);

  localparam logic [ADDR_W-1:0] ADDR_A    = ADDR_W'(6'h00);
  localparam logic [ADDR_W-1:0] ADDR_B    = ADDR_W'(6'h04);
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(6'h08);
  localparam logic [ADDR_W-1:0] ADDR_RES  = ADDR_W'(6'h0C);
  localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(6'h10);

  localparam logic [1:0] STROBE_IDLE = 2'b11;
  localparam logic [1:0] STROBE_32   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_A    = 3'd1,
    S_WR_B    = 3'd2,
    S_WR_CTRL = 3'd3,
    S_POLL    = 3'd4,
    S_RD_RES  = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_q, b_q;
  logic [1:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       result_q;
  logic              err_q;

  logic poll_busy;
  logic poll_last;

  assign poll_busy = bus.bus_rdata[0];
  assign poll_last = (cnt_q == POLL_LAST);
  assign state_o   = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Each bus state advances only on bus_data_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.req_valid) state_d = (bus.req_op == 2'b00) ? S_RESP : S_WR_A;
      S_WR_A:    if (bus.bus_data_ready) state_d = S_WR_B;
      S_WR_B:    if (bus.bus_data_ready) state_d = S_WR_CTRL;
      S_WR_CTRL: if (bus.bus_data_ready) state_d = S_POLL;
      S_POLL: begin
        if (bus.bus_data_ready) begin
          if (!poll_busy)     state_d = S_RD_RES;
          else if (poll_last) state_d = S_RESP;
        end
      end
      S_RD_RES:  if (bus.bus_data_ready) state_d = S_RESP;
      S_RESP:    if (bus.rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: address, data and the single active strobe for each state.
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.bus_address = '0;
    bus.bus_wdata   = '0;
    bus.bus_write_n = STROBE_IDLE;
    bus.bus_read_n  = STROBE_IDLE;
    unique case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_WR_A: begin
        bus.bus_address = ADDR_A;
        bus.bus_wdata   = a_q;
        bus.bus_write_n = STROBE_32;
      end
      S_WR_B: begin
        bus.bus_address = ADDR_B;
        bus.bus_wdata   = b_q;
        bus.bus_write_n = STROBE_32;
      end
      S_WR_CTRL: begin
        bus.bus_address = ADDR_CTRL;
        bus.bus_wdata   = {30'b0, op_q};
        bus.bus_write_n = STROBE_32;
      end
      S_POLL: begin
        bus.bus_address = ADDR_STAT;
        bus.bus_read_n  = STROBE_32;
      end
      S_RD_RES: begin
        bus.bus_address = ADDR_RES;
        bus.bus_read_n  = STROBE_32;
      end
      S_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
    bus.rsp_result = result_q;
    bus.rsp_err    = err_q;
  end

  // Datapath: request capture, poll counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
            op_q <= bus.req_op;
            if (bus.req_op == 2'b00) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        S_WR_CTRL: cnt_q <= '0;
        S_POLL: begin
          if (bus.bus_data_ready && poll_busy) begin
            if (poll_last) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end else begin
              // Saturating: the last poll value exits above, so this never wraps.
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RD_RES: begin
          if (bus.bus_data_ready) begin
            result_q <= bus.bus_rdata;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_bus_initiator.sv
// Directed bench for fpu_bus_initiator: a small FPU register model answers the
// bus. Expected writes, poll counts, results and latencies are hand-computed.
module tb_fpu_bus_initiator;

  localparam int ADDR_W   = 6;
  localparam int POLL_MAX = 64;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [2:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpu_bus_initiator_if #(.ADDR_W(ADDR_W)) bif ();

  fpu_bus_initiator #(.POLL_MAX(POLL_MAX), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+31:0] exp_q[$];

  // Bus model state and logs.
  int                busy_left;
  logic [31:0]       res_val;
  int                stall_left;
  logic [ADDR_W-1:0] stall_addr;
  logic [31:0]       stall_wdata;
  int                stall_seen;
  int                n_poll, n_res, n_other_rd, extra_wr, both_err, strobe_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    n_poll = 0; n_res = 0; n_other_rd = 0; extra_wr = 0;
    both_err = 0; strobe_cnt = 0; stall_seen = 0;
  endtask

  // Peripheral model: answers at the falling edge so the DUT samples stable inputs.
  always @(negedge clk) begin
    logic wr, rd;
    wr = (bif.bus_write_n == 2'b10);
    rd = (bif.bus_read_n == 2'b10);
    if (wr && rd) both_err++;
    if (bif.bus_write_n != 2'b11 || bif.bus_read_n != 2'b11) strobe_cnt++;
    bif.bus_data_ready = 1'b0;
    bif.bus_rdata      = 32'h0;
    if (wr || rd) begin
      if (stall_left > 0 && bif.bus_address == stall_addr) begin
        stall_left--;
        stall_seen++;
        check_eq("stall_addr", bif.bus_address, stall_addr);
        check_eq("stall_wdata", bif.bus_wdata, stall_wdata);
        check_eq("stall_write_n", bif.bus_write_n, 2'b10);
      end else begin
        bif.bus_data_ready = 1'b1;
        if (wr) begin
          if (exp_q.size() == 0) extra_wr++;
          else check_eq("bus_write", {bif.bus_address, bif.bus_wdata}, exp_q.pop_front());
        end else if (bif.bus_address == 6'h10) begin
          n_poll++;
          // Upper bits are junk that the initiator must ignore.
          bif.bus_rdata = 32'hDEADBEE0 | {31'b0, (busy_left > 0)};
          if (busy_left > 0) busy_left--;
        end else if (bif.bus_address == 6'h0C) begin
          n_res++;
          bif.bus_rdata = res_val;
        end else begin
          n_other_rd++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    check_eq("req_ready_before", bif.req_ready, 1'b1);
    bif.req_a = a; bif.req_b = b; bif.req_op = op; bif.req_valid = 1'b1;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
  endtask

  // Issues one request and checks the full transaction. exp_lat is the cycle
  // (edge 0 = acceptance) in which rsp_valid first reads 1.
  task automatic run_op(input string name,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input int busy, input logic [31:0] res,
                        input logic [31:0] exp_res, input logic exp_err,
                        input int exp_lat, input int exp_polls, input int exp_resreads,
                        input int rsp_hold, input int exp_stalls);
    int lat;
    clear_logs();
    busy_left = busy;
    res_val   = res;
    if (op != 2'b00) begin
      exp_q.push_back({6'h00, a});
      exp_q.push_back({6'h04, b});
      exp_q.push_back({6'h08, 30'b0, op});
    end
    send_req(a, b, op);
    lat = 1;
    @(negedge clk);
    while (!bif.rsp_valid && lat < 300) begin
      lat++;
      @(negedge clk);
    end
    check_eq({name, "_latency"}, lat, exp_lat);
    for (int i = 0; i < rsp_hold; i++) begin
      check_eq({name, "_hold_valid"}, bif.rsp_valid, 1'b1);
      check_eq({name, "_hold_result"}, bif.rsp_result, exp_res);
      check_eq({name, "_hold_req_ready"}, bif.req_ready, 1'b0);
      @(negedge clk);
    end
    check_eq({name, "_rsp_valid"}, bif.rsp_valid, 1'b1);
    check_eq({name, "_rsp_result"}, bif.rsp_result, exp_res);
    check_eq({name, "_rsp_err"}, bif.rsp_err, exp_err);
    bif.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bif.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq({name, "_req_ready_after"}, bif.req_ready, 1'b1);
    check_eq({name, "_rsp_valid_after"}, bif.rsp_valid, 1'b0);
    check_eq({name, "_writes_left"}, exp_q.size(), 0);
    check_eq({name, "_extra_writes"}, extra_wr, 0);
    check_eq({name, "_polls"}, n_poll, exp_polls);
    check_eq({name, "_result_reads"}, n_res, exp_resreads);
    check_eq({name, "_other_reads"}, n_other_rd, 0);
    check_eq({name, "_both_strobes"}, both_err, 0);
    check_eq({name, "_stalls"}, stall_seen, exp_stalls);
    if (op == 2'b00) check_eq({name, "_no_strobe"}, strobe_cnt, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bif.req_valid = 1'b0; bif.req_a = '0; bif.req_b = '0; bif.req_op = '0;
    bif.rsp_ready = 1'b0;
    busy_left = 0; res_val = '0; stall_left = 0; stall_addr = '0; stall_wdata = '0;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_req_ready", bif.req_ready, 1'b1);
    check_eq("rst_rsp_valid", bif.rsp_valid, 1'b0);
    check_eq("rst_rsp_result", bif.rsp_result, 32'h0);
    check_eq("rst_rsp_err", bif.rsp_err, 1'b0);
    check_eq("rst_write_n", bif.bus_write_n, 2'b11);
    check_eq("rst_read_n", bif.bus_read_n, 2'b11);
    check_eq("rst_address", bif.bus_address, 6'h0);
    check_eq("rst_wdata", bif.bus_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Add: busy for 2 polls, clears on the 3rd, rsp_valid in cycle 5+3.
    run_op("add", 32'h3F800000, 32'h40000000, 2'b01, 2, 32'h40400000,
           32'h40400000, 1'b0, 8, 3, 1, 0, 0);
    // Mul: busy clear on the first poll, rsp_valid in cycle 6.
    run_op("mul", 32'h40000000, 32'h40400000, 2'b10, 0, 32'h40C00000,
           32'h40C00000, 1'b0, 6, 1, 1, 0, 0);
    // Illegal op: response in cycle 1, no bus activity.
    run_op("illegal", 32'h12345678, 32'h9ABCDEF0, 2'b00, 0, 32'h11111111,
           32'h0, 1'b1, 1, 0, 0, 0, 0);
    // Timeout: busy stuck, 64 polls, rsp_valid in cycle 4+64.
    run_op("timeout", 32'h3F800000, 32'h3F800000, 2'b01, 1000, 32'h22222222,
           32'h0, 1'b1, 68, 64, 0, 0, 0);
    // Stall on WR_B for 3 cycles, busy for 1 poll, rsp_ready held low 5 cycles.
    stall_left = 3; stall_addr = 6'h04; stall_wdata = 32'h40A00000;
    run_op("stall", 32'h3F800000, 32'h40A00000, 2'b01, 1, 32'h40C00000,
           32'h40C00000, 1'b0, 10, 2, 1, 5, 3);
    stall_left = 0;

    // Reset in the middle of polling.
    clear_logs();
    busy_left = 1000;
    exp_q.push_back({6'h00, 32'h40400000});
    exp_q.push_back({6'h04, 32'h3F800000});
    exp_q.push_back({6'h08, 32'h00000003});
    send_req(32'h40400000, 32'h3F800000, 2'b11);
    repeat (7) @(negedge clk);
    check_eq("midrst_in_poll", state_dbg, 3'd4);
    check_eq("midrst_read_active", bif.bus_read_n, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_write_n", bif.bus_write_n, 2'b11);
    check_eq("midrst_read_n", bif.bus_read_n, 2'b11);
    check_eq("midrst_req_ready", bif.req_ready, 1'b1);
    check_eq("midrst_rsp_valid", bif.rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_left = 0;
    @(negedge clk);
    check_eq("postrst_req_ready", bif.req_ready, 1'b1);
    check_eq("postrst_writes_left", exp_q.size(), 0);
    // Sub after reset completes normally.
    run_op("sub", 32'h40400000, 32'h3F800000, 2'b11, 0, 32'h40000000,
           32'h40000000, 1'b0, 6, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

endmodule
